// File: rtl/audio_pkg.sv
// Shared types and constants for the audio job sequencer.
//   state_t    : sequencer FSM states
//   LINE_W     : width of one AudioProcessor data line (32 x 16-bit samples)
//   SAMPLE_W   : width of one audio sample
//   NUM_COEF   : number of frequency-band coefficients
//   COEF_W     : width of one coefficient value
//   SEMI_W     : width of the pitch-shift semitone field
//   CIDX_W     : coefficient index width
//   band_valid : a band is written only when enabled and lo <= hi
package audio_pkg;

  localparam int LINE_W   = 512;
  localparam int SAMPLE_W = 16;
  localparam int NUM_COEF = 2048;
  localparam int COEF_W   = 8;
  localparam int SEMI_W   = 5;
  localparam int CIDX_W   = $clog2(NUM_COEF);

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    CFG_PITCH,
    CFG_TREM,
    CFG_COEF,
    START,
    WAIT,
    DRAIN,
    ERR
  } state_t;

  function automatic logic band_valid(input logic              en,
                                      input logic [CIDX_W-1:0] lo,
                                      input logic [CIDX_W-1:0] hi);
    return en && (lo <= hi);
  endfunction

endpackage

// File: rtl/line_out_stage.sv
// Output holding register with valid/ready handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   cap_en     : load cap_data and raise out_valid (only issued while empty)
//   cap_data   : line read back from the AudioProcessor
//   out_ready  : downstream ready
//   out_valid  : line held in out_data is valid
//   out_data   : held output line, stable while out_valid && !out_ready
module line_out_stage
  import audio_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap_en,
  input  logic [LINE_W-1:0] cap_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [LINE_W-1:0] out_data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (cap_en) begin
      out_data  <= cap_data;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/audio_job_sequencer.sv
// Runs one complete AudioProcessor job per request: load LINES input lines,
// write pitch / tremolo / coefficient-band configuration, pulse start, wait
// for done (with timeout), then drain LINES result lines to a valid/ready
// stream. Sole master of the AudioProcessor control ports.
//   clk, rst_n          : clock, asynchronous active-low reset
//   job_en, cfg_*       : job request and per-job configuration (latched at accept)
//   in_valid/in_ready/in_data    : input line stream
//   out_valid/out_ready/out_data : output line stream
//   ap_*                : AudioProcessor load, config, start and read ports
//   busy, err, err_clr  : status, sticky timeout flag and its clear
//   job_count           : completed jobs (wraps)
module audio_job_sequencer
  import audio_pkg::*;
#(
  parameter int LINES    = 64,
  parameter int READ_LAT = 1,
  parameter int TIMEOUT  = 65535
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       job_en,
  input  logic [SEMI_W-1:0]          cfg_semitones,
  input  logic                       cfg_tremolo,
  input  logic                       cfg_band_en,
  input  logic [CIDX_W-1:0]          cfg_band_lo,
  input  logic [CIDX_W-1:0]          cfg_band_hi,
  input  logic [COEF_W-1:0]          cfg_band_gain,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LINE_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LINE_W-1:0]          out_data,
  output logic                       ap_data_wr_en,
  output logic [$clog2(LINES)-1:0]   ap_input_index,
  output logic [LINE_W-1:0]          ap_data_in,
  output logic                       ap_pitch_shift_wr_en,
  output logic [SEMI_W-1:0]          ap_pitch_shift_semitones,
  output logic                       ap_tremolo_enable_wr_en,
  output logic                       ap_tremolo_enable_in,
  output logic                       ap_freq_coeff_wr_en,
  output logic [CIDX_W-1:0]          ap_freq_coeff_index,
  output logic [COEF_W-1:0]          ap_freq_coeff_in,
  output logic                       ap_start,
  input  logic                       ap_done,
  output logic [$clog2(LINES)-1:0]   ap_output_index,
  input  logic [LINE_W-1:0]          ap_data_out,
  output logic                       busy,
  output logic                       err,
  input  logic                       err_clr,
  output logic [15:0]                job_count
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINES - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LAT - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  state_t              state;
  logic [IDX_W-1:0]    line_cnt;
  logic [SEMI_W-1:0]   semi_q;
  logic                trem_q;
  logic                band_q;
  logic [CIDX_W-1:0]   coef_idx;
  logic [CIDX_W-1:0]   hi_q;
  logic [COEF_W-1:0]   gain_q;
  logic [TO_W-1:0]     wait_cnt;
  logic [LAT_W-1:0]    lat_cnt;
  logic                in_hs;
  logic                out_hs;
  logic                cap_en;

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;
  // Capture once the read address has been stable for READ_LAT cycles and the
  // holding register is empty.
  assign cap_en = (state == DRAIN) && !out_valid && (lat_cnt == LAT_LAST);

  // Input line datapath: the line is registered alongside ap_data_wr_en.
  always_ff @(posedge clk) begin
    if (in_hs) ap_data_in <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                    <= IDLE;
      line_cnt                 <= '0;
      semi_q                   <= '0;
      trem_q                   <= 1'b0;
      band_q                   <= 1'b0;
      coef_idx                 <= '0;
      hi_q                     <= '0;
      gain_q                   <= '0;
      wait_cnt                 <= '0;
      lat_cnt                  <= '0;
      in_ready                 <= 1'b0;
      ap_data_wr_en            <= 1'b0;
      ap_input_index           <= '0;
      ap_pitch_shift_wr_en     <= 1'b0;
      ap_pitch_shift_semitones <= '0;
      ap_tremolo_enable_wr_en  <= 1'b0;
      ap_tremolo_enable_in     <= 1'b0;
      ap_freq_coeff_wr_en      <= 1'b0;
      ap_freq_coeff_index      <= '0;
      ap_freq_coeff_in         <= '0;
      ap_start                 <= 1'b0;
      ap_output_index          <= '0;
      busy                     <= 1'b0;
      err                      <= 1'b0;
      job_count                <= '0;
    end else begin
      // Strobes default low; each state raises its own for one cycle.
      ap_data_wr_en           <= 1'b0;
      ap_pitch_shift_wr_en    <= 1'b0;
      ap_tremolo_enable_wr_en <= 1'b0;
      ap_freq_coeff_wr_en     <= 1'b0;
      ap_start                <= 1'b0;

      case (state)
        IDLE: begin
          if (job_en && !err) begin
            semi_q   <= cfg_semitones;
            trem_q   <= cfg_tremolo;
            band_q   <= band_valid(cfg_band_en, cfg_band_lo, cfg_band_hi);
            coef_idx <= cfg_band_lo;
            hi_q     <= cfg_band_hi;
            gain_q   <= cfg_band_gain;
            line_cnt <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end

        LOAD: begin
          if (in_hs) begin
            ap_data_wr_en  <= 1'b1;
            ap_input_index <= line_cnt;
            line_cnt       <= line_cnt + IDX_W'(1);
            if (line_cnt == LAST_IDX) begin
              in_ready <= 1'b0;
              state    <= CFG_PITCH;
            end
          end
        end

        CFG_PITCH: begin
          ap_pitch_shift_wr_en     <= 1'b1;
          ap_pitch_shift_semitones <= semi_q;
          state                    <= CFG_TREM;
        end

        CFG_TREM: begin
          ap_tremolo_enable_wr_en <= 1'b1;
          ap_tremolo_enable_in    <= trem_q;
          state                   <= band_q ? CFG_COEF : START;
        end

        CFG_COEF: begin
          ap_freq_coeff_wr_en <= 1'b1;
          ap_freq_coeff_index <= coef_idx;
          ap_freq_coeff_in    <= gain_q;
          // Stop on equality so hi = NUM_COEF-1 never wraps the index.
          if (coef_idx == hi_q) state <= START;
          else                  coef_idx <= coef_idx + CIDX_W'(1);
        end

        START: begin
          ap_start <= 1'b1;
          wait_cnt <= '0;
          state    <= WAIT;
        end

        WAIT: begin
          if (ap_done) begin
            ap_output_index <= '0;
            lat_cnt         <= '0;
            state           <= DRAIN;
          end else if (wait_cnt == TO_LAST) begin
            err   <= 1'b1;
            state <= ERR;
          end else begin
            wait_cnt <= wait_cnt + TO_W'(1);
          end
        end

        DRAIN: begin
          if (out_hs) begin
            if (ap_output_index == LAST_IDX) begin
              job_count <= job_count + 16'd1;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              ap_output_index <= ap_output_index + IDX_W'(1);
              lat_cnt         <= '0;
            end
          end else if (!out_valid && lat_cnt != LAT_LAST) begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end

        ERR: begin
          if (err_clr) begin
            err   <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Output stage: holds the captured line until the consumer takes it.
  line_out_stage u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .cap_en    (cap_en),
    .cap_data  (ap_data_out),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

endmodule

// File: tb/tb_audio_job_sequencer.sv
// Self-checking bench for audio_job_sequencer with a behavioural
// AudioProcessor model (result line = bitwise inverse of the loaded line) and
// an output scoreboard filled as input lines are driven.
module tb_audio_job_sequencer;
  import audio_pkg::*;

  localparam int LINES    = 64;
  localparam int READ_LAT = 1;
  localparam int TIMEOUT  = 200;

  logic              clk;
  logic              rst_n;
  logic              job_en;
  logic [SEMI_W-1:0] cfg_semitones;
  logic              cfg_tremolo;
  logic              cfg_band_en;
  logic [CIDX_W-1:0] cfg_band_lo;
  logic [CIDX_W-1:0] cfg_band_hi;
  logic [COEF_W-1:0] cfg_band_gain;
  logic              in_valid;
  logic              in_ready;
  logic [LINE_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [LINE_W-1:0] out_data;
  logic              ap_data_wr_en;
  logic [5:0]        ap_input_index;
  logic [LINE_W-1:0] ap_data_in;
  logic              ap_pitch_shift_wr_en;
  logic [SEMI_W-1:0] ap_pitch_shift_semitones;
  logic              ap_tremolo_enable_wr_en;
  logic              ap_tremolo_enable_in;
  logic              ap_freq_coeff_wr_en;
  logic [CIDX_W-1:0] ap_freq_coeff_index;
  logic [COEF_W-1:0] ap_freq_coeff_in;
  logic              ap_start;
  logic              ap_done;
  logic [5:0]        ap_output_index;
  logic [LINE_W-1:0] ap_data_out;
  logic              busy;
  logic              err;
  logic              err_clr;
  logic [15:0]       job_count;

  audio_job_sequencer #(.LINES(LINES), .READ_LAT(READ_LAT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .job_en(job_en),
    .cfg_semitones(cfg_semitones), .cfg_tremolo(cfg_tremolo),
    .cfg_band_en(cfg_band_en), .cfg_band_lo(cfg_band_lo),
    .cfg_band_hi(cfg_band_hi), .cfg_band_gain(cfg_band_gain),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ap_data_wr_en(ap_data_wr_en), .ap_input_index(ap_input_index),
    .ap_data_in(ap_data_in),
    .ap_pitch_shift_wr_en(ap_pitch_shift_wr_en),
    .ap_pitch_shift_semitones(ap_pitch_shift_semitones),
    .ap_tremolo_enable_wr_en(ap_tremolo_enable_wr_en),
    .ap_tremolo_enable_in(ap_tremolo_enable_in),
    .ap_freq_coeff_wr_en(ap_freq_coeff_wr_en),
    .ap_freq_coeff_index(ap_freq_coeff_index),
    .ap_freq_coeff_in(ap_freq_coeff_in),
    .ap_start(ap_start), .ap_done(ap_done),
    .ap_output_index(ap_output_index), .ap_data_out(ap_data_out),
    .busy(busy), .err(err), .err_clr(err_clr), .job_count(job_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // AudioProcessor model: combinational read, result = ~loaded line.
  logic [LINE_W-1:0] apmem [LINES];
  always @(posedge clk) if (ap_data_wr_en) apmem[ap_input_index] <= ap_data_in;
  assign ap_data_out = ~apmem[ap_output_index];

  logic done_drv, stray_done;
  int   done_delay = -1;
  assign ap_done = done_drv | stray_done;

  initial begin
    done_drv = 1'b0;
    forever begin
      @(negedge clk);
      if (ap_start && done_delay >= 0) begin
        repeat (done_delay) @(posedge clk);
        #1 done_drv = 1'b1;
        @(posedge clk);
        #1 done_drv = 1'b0;
      end
    end
  end

  logic rdy_toggle = 1'b0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 out_ready = rdy_toggle ? ~out_ready : 1'b1;
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [LINE_W-1:0] got,
                     input logic [LINE_W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Monitor / scoreboard state
  int                wr_n, exp_wr_idx, first_wr_cyc, last_wr_cyc;
  int                pitch_n, pitch_cyc, trem_n, trem_cyc, coef_n;
  int                start_n, start_cyc, out_n, out_first_cyc, out_last_cyc, err_cyc;
  logic              err_seen = 1'b0;
  logic              hs_prev = 1'b0;
  logic [LINE_W-1:0] hs_data_prev;
  logic              stall_prev = 1'b0;
  logic [LINE_W-1:0] stall_data;
  logic [SEMI_W-1:0] exp_semi;
  logic              exp_trem;
  logic [CIDX_W-1:0] exp_lo;
  logic [COEF_W-1:0] exp_gain;
  logic [LINE_W-1:0] exp_q [$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (hs_prev || ap_data_wr_en) chk("wr_vs_hs", ap_data_wr_en, hs_prev);
      if (ap_data_wr_en) begin
        chk("wr_idx", ap_input_index, exp_wr_idx);
        chk("wr_data", ap_data_in, hs_data_prev);
        if (wr_n == 0) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
        wr_n++;
        exp_wr_idx++;
      end
      if (ap_pitch_shift_wr_en) begin
        chk("pitch_val", ap_pitch_shift_semitones, exp_semi);
        pitch_n++;
        pitch_cyc = cyc;
      end
      if (ap_tremolo_enable_wr_en) begin
        chk("trem_val", ap_tremolo_enable_in, exp_trem);
        trem_n++;
        trem_cyc = cyc;
      end
      if (ap_freq_coeff_wr_en) begin
        chk("coef_idx", ap_freq_coeff_index, exp_lo + coef_n);
        chk("coef_gain", ap_freq_coeff_in, exp_gain);
        coef_n++;
      end
      if (ap_start) begin
        start_n++;
        start_cyc = cyc;
      end
      if (err && !err_seen) begin
        err_seen = 1'b1;
        err_cyc  = cyc;
      end
      if (stall_prev) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, stall_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("out_extra", out_valid, 0);
        else chk("out_data", out_data, exp_q.pop_front());
        if (out_n == 0) out_first_cyc = cyc;
        out_last_cyc = cyc;
        out_n++;
      end
    end
    hs_prev      = in_valid && in_ready;
    hs_data_prev = in_data;
    stall_prev   = out_valid && !out_ready;
    stall_data   = out_data;
  end

  function automatic logic [LINE_W-1:0] line_pat(input int seed, input int i);
    logic [LINE_W-1:0] r;
    for (int k = 0; k < LINE_W / SAMPLE_W; k++) r[k*SAMPLE_W +: SAMPLE_W] = 16'(i + seed);
    return r;
  endfunction

  task automatic send_line(input logic [LINE_W-1:0] d);
    int k = 0;
    in_valid = 1'b1;
    in_data  = d;
    exp_q.push_back(~d);
    @(negedge clk);
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) chk("in_ready_wait", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int k = 0;
    while (busy && k < maxc) begin
      @(negedge clk);
      k++;
    end
    chk("job_finished", busy, 0);
  endtask

  task automatic run_job(input int seed, input logic [SEMI_W-1:0] semi, input logic trem,
                         input logic ben, input logic [CIDX_W-1:0] lo,
                         input logic [CIDX_W-1:0] hi, input logic [COEF_W-1:0] gain,
                         input int gap, input int ddelay, input int nlines);
    int k = 0;
    wr_n = 0; exp_wr_idx = 0; pitch_n = 0; trem_n = 0; coef_n = 0;
    start_n = 0; out_n = 0; err_seen = 1'b0;
    exp_q.delete();
    exp_semi = semi; exp_trem = trem; exp_lo = lo; exp_gain = gain;
    cfg_semitones = semi; cfg_tremolo = trem; cfg_band_en = ben;
    cfg_band_lo = lo; cfg_band_hi = hi; cfg_band_gain = gain;
    done_delay = ddelay;
    job_en = 1'b1;
    do begin
      @(negedge clk);
      k++;
    end while (!busy && k < 50);
    chk("job_accept", busy, 1);
    @(posedge clk);
    #1 job_en = 1'b0;
    for (int i = 0; i < nlines; i++) begin
      send_line(line_pat(seed, i));
      if (gap != 0 && i < nlines - 1) begin
        @(posedge clk);
        #1;
      end
    end
    if (ddelay >= 0 && nlines == LINES) wait_idle(4000);
  endtask

  task automatic check_job(input int ncoef, input int exp_jobs, input bit b2b);
    chk("wr_count", wr_n, LINES);
    chk("pitch_count", pitch_n, 1);
    chk("trem_count", trem_n, 1);
    chk("coef_count", coef_n, ncoef);
    chk("start_count", start_n, 1);
    chk("pitch_after_load", pitch_cyc - last_wr_cyc, 1);
    chk("trem_after_pitch", trem_cyc - pitch_cyc, 1);
    chk("start_after_trem", start_cyc - trem_cyc, ncoef + 1);
    if (b2b) chk("load_to_start", start_cyc - first_wr_cyc, LINES + 1 + 1 + ncoef);
    chk("out_count", out_n, LINES);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("job_count", job_count, exp_jobs);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int k;
    rst_n = 1'b0; job_en = 1'b0; cfg_semitones = '0; cfg_tremolo = 1'b0;
    cfg_band_en = 1'b0; cfg_band_lo = '0; cfg_band_hi = '0; cfg_band_gain = '0;
    in_valid = 1'b0; in_data = '0; err_clr = 1'b0; stray_done = 1'b0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_err", err, 0);
    chk("rst_job_count", job_count, 0);
    chk("rst_ap_start", ap_start, 0);
    chk("rst_wr_en", ap_data_wr_en, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Job 1: back-to-back lines, upper-half band, stalling consumer.
    rdy_toggle = 1'b1;
    run_job(0, 5'd0, 1'b1, 1'b1, 11'd1024, 11'd2047, 8'd0, 0, 100, LINES);
    check_job(1024, 1, 1'b1);

    // Job 2: band disabled, one-cycle gaps on input, free-running consumer.
    rdy_toggle = 1'b0;
    run_job(3, 5'd7, 1'b0, 1'b0, 11'd0, 11'd100, 8'h5A, 1, 10, LINES);
    check_job(0, 2, 1'b0);
    chk("drain_rate", out_last_cyc - out_first_cyc, (LINES - 1) * (READ_LAT + 1));

    // Job 3: inverted band (lo > hi) writes nothing.
    run_job(5, 5'd31, 1'b1, 1'b1, 11'd5, 11'd3, 8'hAA, 0, 5, LINES);
    check_job(0, 3, 1'b1);

    // Job 4: single-entry band at the top index.
    run_job(7, 5'd1, 1'b0, 1'b1, 11'd2047, 11'd2047, 8'h5C, 0, 3, LINES);
    check_job(1, 4, 1'b1);

    // Stray done while idle is ignored.
    @(posedge clk); #1 stray_done = 1'b1;
    @(posedge clk); #1 stray_done = 1'b0;
    @(negedge clk);
    chk("done_in_idle", busy, 0);

    // Job 5: done never arrives -> timeout.
    run_job(9, 5'd3, 1'b1, 1'b0, 11'd0, 11'd0, 8'h00, 0, -1, LINES);
    k = 0;
    while (!err_seen && k < 3 * TIMEOUT) begin
      @(negedge clk);
      k++;
    end
    chk("err_set", err, 1);
    chk("err_delay", err_cyc - start_cyc, TIMEOUT);
    job_en = 1'b1;
    @(posedge clk); #1 stray_done = 1'b1;
    @(posedge clk); #1 stray_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 job_en = 1'b0;
    @(negedge clk);
    chk("err_busy", busy, 1);
    chk("err_sticky", err, 1);
    chk("err_in_ready", in_ready, 0);
    chk("err_out_valid", out_valid, 0);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    chk("err_cleared", err, 0);
    chk("err_clr_idle", busy, 0);
    chk("err_job_count", job_count, 4);
    exp_q.delete();

    // Job 6: async reset after 20 lines, then a clean job.
    run_job(11, 5'd2, 1'b0, 1'b0, 11'd0, 11'd0, 8'h00, 0, 20, 20);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_wr_en", ap_data_wr_en, 0);
    chk("abort_in_idx", ap_input_index, 0);
    chk("abort_job_count", job_count, 0);
    chk("abort_out_valid", out_valid, 0);
    @(negedge clk) rst_n = 1'b1;
    exp_q.delete();
    run_job(13, 5'd4, 1'b1, 1'b1, 11'd10, 11'd12, 8'h11, 0, 20, LINES);
    check_job(3, 1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
